seq_div: RTL and testbench

Multi-cycle radix-2 restoring divider, the inverse of the team's shift-add sequential multiplier. It produces one quotient bit per clock and sits beside the multiplier in the execute stage's multi-cycle unit. It serves RISC-V DIV/DIVU/REM/REMU (and the W-forms via sign-extended operands). Division by zero and signed overflow follow RISC-V results, so they raise no exception.

---
 rtl/div_pkg.sv | 14 +
 rtl/seq_div_if.sv | 26 ++
 rtl/div_step.sv | 21 ++
 rtl/seq_div.sv | 127 ++++++++++++
 tb/tb_seq_div.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;

  localparam int DIV_WIDTH = 64;

  // Callers sign-extend narrower operands to DIV_WIDTH first; the low bits then hold the magnitude.
  function automatic logic [DIV_WIDTH-1:0] abs_w(input logic [DIV_WIDTH-1:0] value,
                                                 input logic               is_signed);
    return (is_signed && value[DIV_WIDTH-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/seq_div_if.sv
// Request/result bundle between the execute-stage issue logic and seq_div.
interface seq_div_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic             flush;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, flush, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, flush, is_signed, dividend, divisor,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] t;
  logic           unused_r_msb;

  // r stays below d, so its top bit is always clear and drops out of the shift.
  assign unused_r_msb = r[WIDTH];
  assign r_sh         = {r[WIDTH-1:0], q[WIDTH-1]};
  assign t            = r_sh - {1'b0, d};
  assign r_next       = t[WIDTH] ? r_sh : t;
  assign q_next       = {q[WIDTH-2:0], ~t[WIDTH]};
endmodule

// File: rtl/seq_div.sv
// Multi-cycle radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU result semantics.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH  // 2 <= WIDTH <= DIV_WIDTH
) (
  input logic      clk,
  input logic      rst,
  seq_div_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  div_state_t           state;
  div_state_t           state_nxt;
  logic                 accept;
  logic                 div_zero;
  logic                 last_step;
  logic [CNT_W-1:0]     count;
  logic [WIDTH:0]       r;
  logic [WIDTH:0]       r_next;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     q_next;
  logic [WIDTH-1:0]     d;
  logic                 neg_q;
  logic                 neg_r;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;
  logic [DIV_WIDTH-1:0] dvd_ext;
  logic [DIV_WIDTH-1:0] dvs_ext;
  logic [DIV_WIDTH-1:0] dvd_mag;
  logic [DIV_WIDTH-1:0] dvs_mag;

  assign div_zero  = (bus.divisor == '0);
  assign last_step = (count == CNT_W'(WIDTH - 1));

  always_comb begin
    dvd_ext = '0;
    dvs_ext = '0;
    if (bus.is_signed && bus.dividend[WIDTH-1]) dvd_ext = '1;
    if (bus.is_signed && bus.divisor[WIDTH-1])  dvs_ext = '1;
    dvd_ext[WIDTH-1:0] = bus.dividend;
    dvs_ext[WIDTH-1:0] = bus.divisor;
  end

  // MIN has no positive counterpart, but its magnitude fits as an unsigned value.
  assign dvd_mag = abs_w(dvd_ext, bus.is_signed);
  assign dvs_mag = abs_w(dvs_ext, bus.is_signed);

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .q      (q),
    .d      (d),
    .r_next (r_next),
    .q_next (q_next)
  );

  assign q_fix = neg_q ? -q : q;
  assign r_fix = neg_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = div_zero ? DONE : RUN;
        end
      end
      RUN:     if (last_step) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    // Abort wins over everything, including a start arriving on the same edge.
    if (bus.flush) begin
      state_nxt = IDLE;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quo   <= '0;
      rem   <= '0;
    end else if (accept) begin
      if (div_zero) begin
        quo <= '1;
        rem <= bus.dividend;
      end else begin
        q     <= dvd_mag[WIDTH-1:0];
        d     <= dvs_mag[WIDTH-1:0];
        r     <= '0;
        count <= '0;
        neg_q <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
        neg_r <= bus.is_signed & bus.dividend[WIDTH-1];
      end
    end else if (!bus.flush) begin
      if (state == RUN) begin
        r     <= r_next;
        q     <= q_next;
        count <= count + 1'b1;
      end else if (state == FIX) begin
        quo <= q_fix;
        rem <= r_fix;
      end
    end
  end

  assign bus.busy      = (state == RUN) || (state == FIX);
  assign bus.done      = (state == DONE);
  assign bus.quotient  = quo;
  assign bus.remainder = rem;
endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (WIDTH=64) and the div_step iteration.
module tb_seq_div;
  localparam int         W    = 64;
  localparam logic [W-1:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  seq_div_if #(.WIDTH(W)) bus ();

  seq_div #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [8:0] st_r;
  logic [8:0] st_rn;
  logic [7:0] st_q;
  logic [7:0] st_d;
  logic [7:0] st_qn;

  div_step #(.WIDTH(8)) u_step (
    .r      (st_r),
    .q      (st_q),
    .d      (st_d),
    .r_next (st_rn),
    .q_next (st_qn)
  );

  always #5 clk = ~clk;

  // Presents a request for one edge (E0) and returns #1 after it.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded), and busy cycles along the way.
  task automatic wait_done(output int edges, output int busy_cyc);
    edges    = 0;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && edges < 200) begin
      if (bus.busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_ctrl: busy=%b done=%b, expected 0 0", bus.busy, bus.done);
    else passed++;
    total++;
    if (bus.quotient !== '0 || bus.remainder !== '0) $display("FAIL reset_data: q=%h r=%h, expected 0 0", bus.quotient, bus.remainder);
    else passed++;
  endtask

  task automatic test_step();
    logic [8:0] vr  [0:2];
    logic [7:0] vq  [0:2];
    logic [7:0] vd  [0:2];
    logic [8:0] ern [0:2];
    logic [7:0] eqn [0:2];
    vr[0] = 9'd0;   vq[0] = 8'hE4; vd[0] = 8'd5;   ern[0] = 9'd1;   eqn[0] = 8'hC8;
    vr[1] = 9'd4;   vq[1] = 8'h80; vd[1] = 8'd5;   ern[1] = 9'd4;   eqn[1] = 8'h01;
    vr[2] = 9'd200; vq[2] = 8'hFF; vd[2] = 8'd201; ern[2] = 9'd200; eqn[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      st_r = vr[i]; st_q = vq[i]; st_d = vd[i];
      #1;
      total++;
      if (st_rn !== ern[i] || st_qn !== eqn[i])
        $display("FAIL step_%0d: r_next=%h q_next=%h, expected %h %h", i, st_rn, st_qn, ern[i], eqn[i]);
      else passed++;
    end
  endtask

  task automatic test_unsigned();
    int e, b;
    issue(64'd100, 64'd7, 1'b0);
    wait_done(e, b);
    total++;
    if (e !== 65) $display("FAIL u100_7_latency: edges=%0d, expected 65", e); else passed++;
    total++;
    if (b !== 65) $display("FAIL u100_7_busy_cycles: got %0d, expected 65", b); else passed++;
    total++;
    if (bus.quotient !== 64'd14 || bus.remainder !== 64'd2)
      $display("FAIL u100_7_result: q=%h r=%h, expected 14 2", bus.quotient, bus.remainder);
    else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL busy_in_done: busy=%b, expected 0", bus.busy); else passed++;
    @(posedge clk); #1;
    total++;
    if (bus.done !== 1'b0) $display("FAIL done_pulse: done=%b one cycle later, expected 0", bus.done); else passed++;
  endtask

  task automatic test_signed();
    vec_t v [0:1];
    int   e, b;
    v[0] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, ONES};
    v[1] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1};
    for (int i = 0; i < 2; i++) begin
      issue(v[i].a, v[i].b, v[i].s);
      wait_done(e, b);
      total++;
      if (e !== 65 || bus.quotient !== v[i].q || bus.remainder !== v[i].r)
        $display("FAIL signed_%0d: edges=%0d q=%h r=%h, expected 65 %h %h", i, e, bus.quotient, bus.remainder, v[i].q, v[i].r);
      else passed++;
    end
  endtask

  task automatic test_div_zero();
    vec_t v [0:2];
    int   e, b;
    v[0] = '{64'd5, 64'd0, 1'b0, ONES, 64'd5};
    v[1] = '{64'd5, 64'd0, 1'b1, ONES, 64'd5};
    v[2] = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, ONES, 64'hFFFF_FFFF_FFFF_FFFB};
    for (int i = 0; i < 3; i++) begin
      issue(v[i].a, v[i].b, v[i].s);
      wait_done(e, b);
      total++;
      if (e !== 0 || b !== 0 || bus.busy !== 1'b0)
        $display("FAIL div0_%0d_timing: edges=%0d busy_cycles=%0d busy=%b, expected 0 0 0", i, e, b, bus.busy);
      else passed++;
      total++;
      if (bus.quotient !== v[i].q || bus.remainder !== v[i].r)
        $display("FAIL div0_%0d_result: q=%h r=%h, expected %h %h", i, bus.quotient, bus.remainder, v[i].q, v[i].r);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_corners();
    vec_t v [0:12];
    int   e, b;
    v[0]  = '{ONES, 64'd1, 1'b0, ONES, 64'd0};
    v[1]  = '{64'd0, 64'd5, 1'b0, 64'd0, 64'd0};
    v[2]  = '{MIN, 64'd1, 1'b1, MIN, 64'd0};
    v[3]  = '{MAX, ONES, 1'b1, 64'h8000_0000_0000_0001, 64'd0};
    v[4]  = '{MIN, MAX, 1'b1, ONES, ONES};
    v[5]  = '{MIN, ONES, 1'b0, 64'd0, MIN};
    v[6]  = '{ONES, ONES, 1'b0, 64'd1, 64'd0};
    v[7]  = '{ONES, ONES, 1'b1, 64'd1, 64'd0};
    v[8]  = '{64'hFFFF_FFFF_FFFF_FFF8, 64'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE};
    v[9]  = '{MIN, 64'd2, 1'b1, 64'hC000_0000_0000_0000, 64'd0};
    v[10] = '{MIN, ONES, 1'b1, MIN, 64'd0};
    v[11] = '{64'd1, ONES, 1'b1, ONES, 64'd0};
    v[12] = '{MAX, 64'd2, 1'b0, 64'h3FFF_FFFF_FFFF_FFFF, 64'd1};
    for (int i = 0; i < 13; i++) begin
      issue(v[i].a, v[i].b, v[i].s);
      wait_done(e, b);
      total++;
      if (e !== 65 || bus.quotient !== v[i].q || bus.remainder !== v[i].r)
        $display("FAIL corner_%0d: edges=%0d q=%h r=%h, expected 65 %h %h", i, e, bus.quotient, bus.remainder, v[i].q, v[i].r);
      else passed++;
    end
  endtask

  task automatic test_flush();
    int e, b;
    int seen;
    issue(64'd100, 64'd7, 1'b0);
    wait_done(e, b);
    issue(64'd1000, 64'd3, 1'b0);
    repeat (29) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL flush_idle: busy=%b done=%b, expected 0 0", bus.busy, bus.done);
    else passed++;
    total++;
    if (bus.quotient !== 64'd14 || bus.remainder !== 64'd2)
      $display("FAIL flush_hold: q=%h r=%h, expected 14 2", bus.quotient, bus.remainder);
    else passed++;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen !== 0) $display("FAIL flush_no_done: %0d active cycles after flush, expected 0", seen); else passed++;
    // flush and start on the same edge: the start must be dropped
    bus.flush = 1'b1;
    issue(64'd50, 64'd5, 1'b0);
    bus.flush = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL flush_start: busy=%b done=%b, expected 0 0", bus.busy, bus.done);
    else passed++;
    issue(ONES, 64'h10, 1'b0);
    wait_done(e, b);
    total++;
    if (e !== 65 || bus.quotient !== 64'h0FFF_FFFF_FFFF_FFFF || bus.remainder !== 64'hF)
      $display("FAIL after_flush: edges=%0d q=%h r=%h, expected 65 0fffffffffffffff f", e, bus.quotient, bus.remainder);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int e, b;
    issue(64'd100, 64'd7, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    #3 rst = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0)
      $display("FAIL async_reset: busy=%b done=%b q=%h r=%h, expected all 0", bus.busy, bus.done, bus.quotient, bus.remainder);
    else passed++;
    #1 rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_stays_idle: busy=%b, expected 0", bus.busy); else passed++;
    issue(64'd1000, 64'd10, 1'b0);
    wait_done(e, b);
    total++;
    if (e !== 65 || bus.quotient !== 64'd100 || bus.remainder !== 64'd0)
      $display("FAIL after_reset: edges=%0d q=%h r=%h, expected 65 100 0", e, bus.quotient, bus.remainder);
    else passed++;
  endtask

  task automatic test_start_while_busy();
    int e, b;
    issue(64'd100, 64'd7, 1'b0);
    bus.start    = 1'b1;
    bus.dividend = 64'd1000;
    bus.divisor  = 64'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    wait_done(e, b);
    total++;
    if (e + 10 !== 65 || bus.quotient !== 64'd14 || bus.remainder !== 64'd2)
      $display("FAIL start_busy: edges=%0d q=%h r=%h, expected 65 14 2", e + 10, bus.quotient, bus.remainder);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int e, b;
    issue(64'd100, 64'd7, 1'b0);
    wait_done(e, b);
    issue(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    wait_done(e, b);
    total++;
    if (e !== 65 || bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFD || bus.remainder !== 64'd1)
      $display("FAIL b2b_signed: edges=%0d q=%h r=%h, expected 65 fffffffffffffffd 1", e, bus.quotient, bus.remainder);
    else passed++;
    issue(64'd5, 64'd0, 1'b0);
    wait_done(e, b);
    total++;
    if (e !== 0 || bus.quotient !== ONES || bus.remainder !== 64'd5)
      $display("FAIL b2b_div0: edges=%0d q=%h r=%h, expected 0 ffffffffffffffff 5", e, bus.quotient, bus.remainder);
    else passed++;
    issue(MIN, 64'd2, 1'b0);
    wait_done(e, b);
    total++;
    if (e !== 65 || bus.quotient !== 64'h4000_0000_0000_0000 || bus.remainder !== 64'd0)
      $display("FAIL b2b_unsigned: edges=%0d q=%h r=%h, expected 65 4000000000000000 0", e, bus.quotient, bus.remainder);
    else passed++;
  endtask

  initial begin
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    st_r = '0; st_q = '0; st_d = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    test_step();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_corners();
    test_flush();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
